weight_fifo_arr_control: RTL

//  Weight-load stage directly downstream of the master multiply controller.
//  On a weight_fifo_arr_en pulse it reads one weight sub-matrix from weight

---
 rtl/weight_fifo_arr_control.sv | 117 +++++++++++
 1 files changed

// File: rtl/weight_fifo_arr_control.sv
// weight_fifo_arr_control
// Weight-load stage that follows the master multiply controller. A start pulse
// reads one weight sub-matrix from weight memory, one row per cycle. It always
// pushes exactly WIDTH_HEIGHT rows into the weight FIFO, using zero rows to pad
// short matrices. It then pulses arr_load to move the FIFO into the systolic
// array, and finally pulses weight_fifo_arr_done.
// Optional build macro: WEIGHT_ROW_REVERSE_EN puts the pad slots first and then
// reads the real rows in descending address order. With this order the base row
// is pushed last and lands in array row 0.
module weight_fifo_arr_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int DATA_WIDTH   = WIDTH_HEIGHT * 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              weight_fifo_arr_en,
  input  logic [$clog2(WIDTH_HEIGHT):0]     num_rows,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  output logic                              wmem_rd_en,
  output logic [ADDR_WIDTH-1:0]             wmem_addr,
  input  logic [DATA_WIDTH-1:0]             wmem_rd_data,
  output logic                              fifo_push,
  output logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              arr_load,
  output logic                              busy,
  output logic                              weight_fifo_arr_done
);

  localparam int CW = $clog2(WIDTH_HEIGHT) + 1;
  localparam logic [CW-1:0] WH   = CW'(WIDTH_HEIGHT);
  localparam logic [CW-1:0] LAST = CW'(WIDTH_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, LOAD, DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         k;
  logic [CW-1:0]         nr;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  push_q;
  logic                  real_q;
  logic                  slot_real;
  logic [CW-1:0]         offset;
  logic                  rd_active;
  logic [ADDR_WIDTH-1:0] addr_calc;

  // Decide whether FILL slot k reads a real row, and which row offset it reads.
  always_comb begin
    slot_real = 1'b0;
    offset    = '0;
`ifdef WEIGHT_ROW_REVERSE_EN
    slot_real = (k >= (WH - nr));
    offset    = LAST - k;
`else
    slot_real = (k < nr);
    offset    = k;
`endif
    rd_active = (state == FILL) && slot_real;
    addr_calc = base + ADDR_WIDTH'(offset);
  end

  // State register. Reset drops any operation in flight straight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing: IDLE -> FILL (W cycles) -> FLUSH -> LOAD -> DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (weight_fifo_arr_en) state_next = FILL;
      FILL:    if (k == LAST) state_next = FLUSH;
      FLUSH:   state_next = LOAD;
      LOAD:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the job on start, step the slot counter, remember the last read
  // address, and register the push strobe one cycle behind each FILL slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      nr        <= '0;
      base      <= '0;
      addr_hold <= '0;
      push_q    <= 1'b0;
      real_q    <= 1'b0;
    end else begin
      push_q <= (state == FILL);
      real_q <= rd_active;
      if (state == IDLE && weight_fifo_arr_en) begin
        base <= base_addr;
        nr   <= (num_rows > WH) ? WH : num_rows;
        k    <= '0;
      end else if (state == FILL) begin
        k <= k + CW'(1);
      end
      if (rd_active) addr_hold <= addr_calc;
    end
  end

  // Output decode. Pad slots push zeros, and the address is held when no read is issued.
  always_comb begin
    wmem_rd_en           = rd_active;
    wmem_addr            = rd_active ? addr_calc : addr_hold;
    fifo_push            = push_q;
    fifo_data            = (push_q && real_q) ? wmem_rd_data : '0;
    arr_load             = (state == LOAD);
    weight_fifo_arr_done = (state == DONE);
    busy                 = (state != IDLE);
  end

endmodule
